ddr2_cmd_arbiter: RTL and testbench

DDR2_CMD_ARBITER -- requirements
Module: ddr2_cmd_arbiter

---
 rtl/ddr2_pkg.sv | 19 +
 rtl/ddr2_ref_timer.sv | 61 ++++++
 rtl/ddr2_cmd_arbiter.sv | 125 ++++++++++++
 tb/tb_ddr2_cmd_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_pkg.sv
// ---------------------------------------------------------------------------
// ddr2_pkg
// Shared definitions for the DDR2 command arbiter slice:
//   arb_state_e     - arbiter FSM state encoding
//   REF_CYCLES_DEF  - default auto-refresh interval in sys_clk cycles
//                     (7.8 us at 100 MHz)
// ---------------------------------------------------------------------------
package ddr2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AREF  = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } arb_state_e;

  localparam int unsigned REF_CYCLES_DEF = 780;

endpackage

// File: rtl/ddr2_ref_timer.sv
// ---------------------------------------------------------------------------
// ddr2_ref_timer
// Auto-refresh interval timer. Counts 0..REF_CYCLES-1 while init_end is high
// and raises aref_pend on every wrap. aref_pend is dropped when the arbiter
// accepts the refresh (aref_ack); a wrap in the same cycle wins so that the
// new interval is not lost. A wrap that finds a refresh still pending sets
// the sticky aref_miss flag, which only reset clears.
//
// Ports:
//   sys_clk    in  clock, rising edge
//   sys_rst_n  in  asynchronous active-low reset
//   init_end   in  DDR2 initialisation complete; low clears timer and pend
//   aref_ack   in  arbiter is entering AREF on this edge
//   aref_pend  out refresh owed to the memory
//   aref_miss  out sticky: interval elapsed with a refresh still owed
// ---------------------------------------------------------------------------
module ddr2_ref_timer
  import ddr2_pkg::*;
#(
  parameter int unsigned REF_CYCLES = REF_CYCLES_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic init_end,
  input  logic aref_ack,
  output logic aref_pend,
  output logic aref_miss
);

  localparam int TMR_W = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;

  logic [TMR_W-1:0] tmr;
  logic             wrap;

  assign wrap = init_end && (tmr == TMR_W'(REF_CYCLES - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tmr       <= '0;
      aref_pend <= 1'b0;
      aref_miss <= 1'b0;
    end else if (!init_end) begin
      // Memory not usable: restart the interval from scratch once it is.
      tmr       <= '0;
      aref_pend <= 1'b0;
    end else begin
      tmr <= wrap ? '0 : tmr + 1'b1;
      if (wrap) begin
        aref_pend <= 1'b1;
      end else if (aref_ack) begin
        aref_pend <= 1'b0;
      end
      // A wrap that coincides with acceptance is not a miss: the old
      // refresh is being served and the new one becomes pending.
      if (wrap && aref_pend && !aref_ack) begin
        aref_miss <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr2_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// ddr2_cmd_arbiter
// Arbitrates the DDR2 command bus between the auto-refresh, write-burst and
// read-burst executors. Refresh always wins from IDLE; write versus read is
// fixed write-priority by default, or round-robin when the macro
// DDR2_ARB_RR_EN is defined. Grants are levels held until the matching
// *_end pulse, and every grant is followed by at least one IDLE cycle.
// Dropping init_end forces the arbiter back to IDLE on the next edge.
//
// Ports:
//   sys_clk    in  clock, rising edge
//   sys_rst_n  in  asynchronous active-low reset
//   init_end   in  DDR2 initialisation complete (level)
//   wr_req     in  write-burst request, held until granted
//   rd_req     in  read-burst request, held until granted
//   aref_end   in  refresh executor done (1-cycle pulse)
//   wr_end     in  write executor done (1-cycle pulse)
//   rd_end     in  read executor done (1-cycle pulse)
//   aref_en    out refresh grant (level)
//   wr_en      out write grant (level)
//   rd_en      out read grant (level)
//   aref_miss  out sticky refresh-overrun flag
//
// Configuration macro: DDR2_ARB_RR_EN (round-robin write/read arbitration)
// ---------------------------------------------------------------------------
module ddr2_cmd_arbiter
  import ddr2_pkg::*;
#(
  parameter int unsigned REF_CYCLES = REF_CYCLES_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic init_end,
  input  logic wr_req,
  input  logic rd_req,
  input  logic aref_end,
  input  logic wr_end,
  input  logic rd_end,
  output logic aref_en,
  output logic wr_en,
  output logic rd_en,
  output logic aref_miss
);

  arb_state_e state;
  arb_state_e state_nxt;
  logic       aref_pend;
  logic       aref_ack;
  logic       pick_wr;

  ddr2_ref_timer #(
    .REF_CYCLES (REF_CYCLES)
  ) u_ref_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .init_end  (init_end),
    .aref_ack  (aref_ack),
    .aref_pend (aref_pend),
    .aref_miss (aref_miss)
  );

  // Refresh is accepted on the edge that moves IDLE into AREF.
  assign aref_ack = (state == IDLE) && (state_nxt == AREF);

`ifdef DDR2_ARB_RR_EN
  // last_wr=1: write was granted most recently. Reset means "read last",
  // so the first contested cycle goes to write.
  logic last_wr;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_wr <= 1'b0;
    end else if (state == IDLE && state_nxt == WRITE) begin
      last_wr <= 1'b1;
    end else if (state == IDLE && state_nxt == READ) begin
      last_wr <= 1'b0;
    end
  end

  assign pick_wr = !last_wr;
`else
  assign pick_wr = 1'b1;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!init_end) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // pick_wr only matters when both sides are requesting.
          if (aref_pend) begin
            state_nxt = AREF;
          end else if (wr_req && (!rd_req || pick_wr)) begin
            state_nxt = WRITE;
          end else if (rd_req) begin
            state_nxt = READ;
          end
        end
        AREF:    if (aref_end) state_nxt = IDLE;
        WRITE:   if (wr_end)   state_nxt = IDLE;
        READ:    if (rd_end)   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Grants decode straight from the state register, so reset clears them
  // immediately and they never depend combinationally on inputs.
  always_comb begin
    aref_en = (state == AREF);
    wr_en   = (state == WRITE);
    rd_en   = (state == READ);
  end

endmodule

// File: tb/tb_ddr2_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr2_cmd_arbiter
// Scoreboard bench for ddr2_cmd_arbiter with REF_CYCLES=16. A behavioural
// model predicts the four outputs for every clock and queues them; a monitor
// on the falling edge pops and compares. Directed scenarios are followed by
// a randomized phase with random requests, burst lengths, stray end pulses,
// init_end drops and resets. Define DDR2_ARB_RR_EN for the round-robin build.
// ---------------------------------------------------------------------------
module tb_ddr2_cmd_arbiter;

  localparam int REF = 16;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic init_end  = 1'b0;
  logic wr_req    = 1'b0;
  logic rd_req    = 1'b0;
  logic aref_end  = 1'b0;
  logic wr_end    = 1'b0;
  logic rd_end    = 1'b0;
  logic aref_en, wr_en, rd_en, aref_miss;

  ddr2_cmd_arbiter #(.REF_CYCLES(REF)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .init_end  (init_end),
    .wr_req    (wr_req),
    .rd_req    (rd_req),
    .aref_end  (aref_end),
    .wr_end    (wr_end),
    .rd_end    (rd_end),
    .aref_en   (aref_en),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .aref_miss (aref_miss)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [3:0] exp_q[$];
  int         grant_log[$];   // 1=refresh, 2=write, 3=read, in grant order

  // ---------------- reference model ----------------
  // Grant held: 0 none, 1 refresh, 2 write, 3 read. The refresh interval is
  // tracked as a count of cycles since init_end came up.
  int m_grant = 0;
  int m_n     = 0;
  bit m_pend  = 0;
  bit m_miss  = 0;
  bit m_lastw = 0;
  bit m_wrap, m_take_ref, m_pend_old;

  always @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      m_grant = 0; m_n = 0; m_pend = 0; m_miss = 0; m_lastw = 0;
    end else if (!init_end) begin
      m_grant = 0; m_n = 0; m_pend = 0;
    end else begin
      m_pend_old = m_pend;
      m_wrap     = ((m_n % REF) == REF - 1);
      m_n        = m_n + 1;
      m_take_ref = 0;
      if (m_grant == 0) begin
        if (m_pend_old) begin
          m_grant = 1; m_take_ref = 1;
        end else if (wr_req && rd_req) begin
`ifdef DDR2_ARB_RR_EN
          m_grant = m_lastw ? 3 : 2;
`else
          m_grant = 2;
`endif
        end else if (wr_req) begin
          m_grant = 2;
        end else if (rd_req) begin
          m_grant = 3;
        end
      end else if ((m_grant == 1 && aref_end) || (m_grant == 2 && wr_end) ||
                   (m_grant == 3 && rd_end)) begin
        m_grant = 0;
      end
      if (m_grant == 2) m_lastw = 1;
      if (m_grant == 3) m_lastw = 0;
      if (m_wrap && m_pend_old && !m_take_ref) m_miss = 1;
      if (m_wrap) m_pend = 1;
      else if (m_take_ref) m_pend = 0;
    end
    exp_q.push_back({m_grant == 1, m_grant == 2, m_grant == 3, m_miss});
  end

  // ---------------- monitor ----------------
  logic [3:0] mon_exp, mon_act;
  logic p_a = 1'b0, p_w = 1'b0, p_r = 1'b0;

  always @(negedge sys_clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {aref_en, wr_en, rd_en, aref_miss};
      n_vec++;
      if (mon_act !== mon_exp) begin
        n_bad++;
        $display("FAIL outputs t=%0t aref/wr/rd/miss got %b want %b",
                 $time, mon_act, mon_exp);
      end
    end
    if (aref_en && !p_a) grant_log.push_back(1);
    if (wr_en && !p_w)   grant_log.push_back(2);
    if (rd_en && !p_r)   grant_log.push_back(3);
    p_a = aref_en; p_w = wr_en; p_r = rd_en;
  end

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- stimulus / executor emulation ----------------
  int lat_a = 2, lat_w = 2, lat_r = 2;
  int cnt_a = 0, cnt_w = 0, cnt_r = 0;
  bit rand_lat = 0, rand_req = 0, drop_on_grant = 0, stray = 0;

  // One clock of executor and requester behaviour, driven at the falling edge.
  task automatic cycle();
    @(negedge sys_clk);
    aref_end = 1'b0; wr_end = 1'b0; rd_end = 1'b0;
    if (aref_en) begin
      if (cnt_a >= lat_a) begin
        aref_end = 1'b1; cnt_a = 0;
        if (rand_lat) lat_a = ($urandom_range(0, 9) == 0) ? 40 : $urandom_range(0, 6);
      end else cnt_a++;
    end else cnt_a = 0;
    if (wr_en) begin
      if (cnt_w >= lat_w) begin
        wr_end = 1'b1; cnt_w = 0;
        if (rand_lat) lat_w = $urandom_range(0, 8);
      end else cnt_w++;
    end else cnt_w = 0;
    if (rd_en) begin
      if (cnt_r >= lat_r) begin
        rd_end = 1'b1; cnt_r = 0;
        if (rand_lat) lat_r = $urandom_range(0, 8);
      end else cnt_r++;
    end else cnt_r = 0;
    if (drop_on_grant) begin
      if (wr_en) wr_req = 1'b0;
      if (rd_en) rd_req = 1'b0;
    end
    if (rand_req) begin
      if (!wr_req && !wr_en && $urandom_range(0, 3) == 0) wr_req = 1'b1;
      if (!rd_req && !rd_en && $urandom_range(0, 3) == 0) rd_req = 1'b1;
    end
    if (stray && $urandom_range(0, 9) == 0) begin
      case ($urandom_range(0, 2))
        0:       if (!aref_en) aref_end = 1'b1;
        1:       if (!wr_en)   wr_end   = 1'b1;
        default: if (!rd_en)   rd_end   = 1'b1;
      endcase
    end
  endtask

  // Called at a falling edge; leaves the DUT out of reset at a falling edge.
  task automatic do_reset();
    #1 sys_rst_n = 1'b0;
    init_end = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    repeat (2) cycle();
    sys_rst_n = 1'b1;
  endtask

  // Runs n cycles; returns the first cycle (1-based) with aref_en high and
  // how many cycles aref_en was high.
  task automatic run_measure(input int n, output int first_a, output int len_a);
    first_a = -1; len_a = 0;
    for (int i = 1; i <= n; i++) begin
      cycle();
      if (aref_en) begin
        if (first_a < 0) first_a = i;
        len_a++;
      end
    end
  endtask

  int f_a, l_a;
  int wr_rd[$];

  initial begin
    repeat (2) cycle();
    sys_rst_n = 1'b1;
    cycle();
    check("idle_after_reset", {aref_en, wr_en, rd_en, aref_miss}, 0);

    // Refresh only: first wrap at cycle REF, grant one cycle later.
    do_reset();
    lat_a = 5; init_end = 1'b1;
    run_measure(30, f_a, l_a);
    check("aref_first_grant", f_a, REF + 1);
    check("aref_len", l_a, 5 + 1);

    // Both requests held continuously.
    do_reset();
    lat_w = 1; lat_r = 1; wr_req = 1'b1; rd_req = 1'b1; init_end = 1'b1;
    grant_log.delete();
    repeat (14) cycle();
    wr_rd.delete();
    foreach (grant_log[i]) if (grant_log[i] != 1) wr_rd.push_back(grant_log[i]);
    check("wr_rd_grant_count_ge4", (wr_rd.size() >= 4) ? 1 : 0, 1);
    for (int i = 0; i < 4; i++) begin
`ifdef DDR2_ARB_RR_EN
      check("rr_order", (i < wr_rd.size()) ? wr_rd[i] : -1, (i % 2 == 0) ? 2 : 3);
`else
      check("fixed_order", (i < wr_rd.size()) ? wr_rd[i] : -1, 2);
`endif
    end

    // Refresh comes due during a long write; it is served before the read.
    do_reset();
    drop_on_grant = 1; lat_w = 20; lat_a = 2; lat_r = 2;
    wr_req = 1'b1; init_end = 1'b1;
    grant_log.delete();
    repeat (10) cycle();
    rd_req = 1'b1;
    repeat (30) cycle();
    check("burst_order_len", grant_log.size() >= 3 ? 1 : 0, 1);
    check("burst_order_0", grant_log.size() > 0 ? grant_log[0] : -1, 2);
    check("burst_order_1", grant_log.size() > 1 ? grant_log[1] : -1, 1);
    check("burst_order_2", grant_log.size() > 2 ? grant_log[2] : -1, 3);

    // Refresh withheld across further wraps: sticky miss.
    do_reset();
    lat_a = 60; init_end = 1'b1;
    repeat (70) cycle();
    check("aref_miss_set", aref_miss, 1);
    lat_a = 2;
    repeat (30) cycle();
    check("aref_miss_sticky", aref_miss, 1);
    do_reset();
    cycle();
    check("aref_miss_reset", aref_miss, 0);

    // init_end dropped during a read.
    do_reset();
    drop_on_grant = 1; lat_r = 30; rd_req = 1'b1; init_end = 1'b1;
    repeat (5) cycle();
    check("rd_granted", rd_en, 1);
    init_end = 1'b0;
    cycle();
    check("rd_dropped", rd_en, 0);
    repeat (5) cycle();
    lat_a = 3; init_end = 1'b1;
    run_measure(REF + 4, f_a, l_a);
    check("aref_after_reinit", f_a, REF + 1);

    // Reset mid-write clears outputs at once; stray wr_end in IDLE ignored.
    do_reset();
    drop_on_grant = 1; lat_w = 50; wr_req = 1'b1; init_end = 1'b1;
    repeat (5) cycle();
    check("wr_before_reset", wr_en, 1);
    #1 sys_rst_n = 1'b0; wr_req = 1'b0;
    #1 check("outputs_at_reset", {aref_en, wr_en, rd_en, aref_miss}, 0);
    repeat (2) cycle();
    sys_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      wr_end = 1'b1;
    end
    cycle();
    check("stray_wr_end_idle", {aref_en, wr_en, rd_en}, 0);

    // Randomized traffic.
    do_reset();
    rand_lat = 1; rand_req = 1; drop_on_grant = 1; stray = 1;
    init_end = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (init_end && $urandom_range(0, 199) == 0) init_end = 1'b0;
      else if (!init_end && $urandom_range(0, 9) == 0) init_end = 1'b1;
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
        init_end = 1'b1;
      end
    end
    rand_req = 0; stray = 0;
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
